// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: branch kind codes and the counter reset value.
package branch_pkg;

   localparam int unsigned BR_TYPE_W = 3;

   typedef enum logic [BR_TYPE_W-1:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLT  = 3'd3,
      BR_BGE  = 3'd4,
      BR_BLTU = 3'd5,
      BR_BGEU = 3'd6,
      BR_JUMP = 3'd7
   } br_type_e;

   // Weakly-not-taken: MSB clear, all lower bits set (01 for a 2-bit counter).
   function automatic logic [31:0] weak_nt(input int unsigned cnt_w);
      return (32'd1 << (cnt_w - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Fetch-lookup, EX-resolve and redirect signals of the branch unit.
// master: pipeline side driving fetch/EX state; slave: the branch unit.
interface branch_unit_if #(
   parameter int unsigned PC_W = 32
);
   import branch_pkg::*;

   logic [PC_W-1:0]      if_pc;
   logic                 if_pred_taken;
   logic                 ex_valid;
   logic [PC_W-1:0]      ex_pc;
   logic [BR_TYPE_W-1:0] ex_br_type;
   logic                 ex_zero;
   logic                 ex_lt;
   logic                 ex_ltu;
   logic                 ex_pred_taken;
   logic [PC_W-1:0]      ex_target;
   logic [PC_W-1:0]      ex_pc_plus4;
   logic                 redirect_valid;
   logic [PC_W-1:0]      redirect_pc;
   logic [31:0]          branch_cnt;
   logic [31:0]          mispred_cnt;

   modport master (
      output if_pc, ex_valid, ex_pc, ex_br_type, ex_zero, ex_lt, ex_ltu, ex_pred_taken,
             ex_target, ex_pc_plus4,
      input  if_pred_taken, redirect_valid, redirect_pc, branch_cnt, mispred_cnt
   );

   modport slave (
      input  if_pc, ex_valid, ex_pc, ex_br_type, ex_zero, ex_lt, ex_ltu, ex_pred_taken,
             ex_target, ex_pc_plus4,
      output if_pred_taken, redirect_valid, redirect_pc, branch_cnt, mispred_cnt
   );

endinterface

// File: rtl/branch_bht.sv
// Branch history table: saturating counters, asynchronous read of the MSB,
// synchronous update. A same-cycle read of the updated index sees the old value.
module branch_bht
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 2,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(weak_nt(CNT_W));

   logic [CNT_W-1:0] cnt_q [DEPTH];

   assign rd_taken = cnt_q[rd_idx][CNT_W-1];

   // Counter array: reset to weakly-not-taken, saturating +/-1 on update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) cnt_q[i] <= CNT_RST;
      end else if (upd_en) begin
         if (upd_taken && (cnt_q[upd_idx] != '1)) begin
            cnt_q[upd_idx] <= cnt_q[upd_idx] + CNT_W'(1);
         end else if (!upd_taken && (cnt_q[upd_idx] != '0)) begin
            cnt_q[upd_idx] <= cnt_q[upd_idx] - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: EX-stage condition resolve, PC-indexed prediction table and a
// registered redirect/flush one cycle after a mispredicting resolve.
// Optional feature macro: BRANCH_STATS_EN (resolved-branch and mispredict counters).
module branch_unit
   import branch_pkg::*;
#(
   parameter int unsigned PC_W      = 32,
   parameter int unsigned BHT_DEPTH = 16,
   parameter int unsigned CNT_W     = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   branch_unit_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

   logic            taken;
   logic            live;
   logic            mispred;
   logic            redirect_valid_q;
   logic [PC_W-1:0] redirect_pc_q;

   // Only pc[IDX_W+1:2] indexes the table.
   logic unused_pc;
   assign unused_pc = ^{bus.if_pc, bus.ex_pc};

   // Condition decode for the eight branch kinds.
   always_comb begin
      taken = 1'b0;
      case (bus.ex_br_type)
         BR_BEQ:  taken = bus.ex_zero;
         BR_BNE:  taken = !bus.ex_zero;
         BR_BLT:  taken = bus.ex_lt;
         BR_BGE:  taken = !bus.ex_lt;
         BR_BLTU: taken = bus.ex_ltu;
         BR_BGEU: taken = !bus.ex_ltu;
         BR_JUMP: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // The EX instruction in a redirect cycle is wrong-path and is ignored.
   assign live    = bus.ex_valid && (bus.ex_br_type != BR_NONE) && !redirect_valid_q;
   assign mispred = live && (taken != bus.ex_pred_taken);

   branch_bht #(
      .DEPTH (BHT_DEPTH),
      .CNT_W (CNT_W),
      .IDX_W (IDX_W)
   ) u_bht (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (bus.if_pc[IDX_W+1:2]),
      .rd_taken  (bus.if_pred_taken),
      .upd_en    (live && (bus.ex_br_type != BR_JUMP)),
      .upd_idx   (bus.ex_pc[IDX_W+1:2]),
      .upd_taken (taken)
   );

   // Redirect registers: pulse on mispredict, corrected PC held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         redirect_valid_q <= mispred;
         if (mispred) redirect_pc_q <= taken ? bus.ex_target : bus.ex_pc_plus4;
      end
   end

   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] mispred_cnt_q;

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (live && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 32'd1;
         if (mispred && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign bus.branch_cnt  = branch_cnt_q;
   assign bus.mispred_cnt = mispred_cnt_q;
`else
   assign bus.branch_cnt  = 32'd0;
   assign bus.mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit (default 32-bit PC, 16 entries, 2-bit counters).
// Expected statistics depend on BRANCH_STATS_EN.
module tb_branch_unit;
   import branch_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;
   int   exp_br = 0;
   int   exp_mp = 0;
   logic [31:0] held_rpc = 32'd0;

   branch_unit_if #(.PC_W(32)) bus ();

   branch_unit #(
      .PC_W      (32),
      .BHT_DEPTH (16),
      .CNT_W     (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pred(input logic [31:0] pc, input logic exp, input string tag);
      @(negedge clk);
      bus.if_pc = pc;
      #1;
      chk(tag, {31'd0, bus.if_pred_taken}, {31'd0, exp});
   endtask

   task automatic stats(input string tag);
`ifdef BRANCH_STATS_EN
      chk({tag, ".br"}, bus.branch_cnt, exp_br);
      chk({tag, ".mp"}, bus.mispred_cnt, exp_mp);
`else
      chk({tag, ".br"}, bus.branch_cnt, 32'd0);
      chk({tag, ".mp"}, bus.mispred_cnt, 32'd0);
`endif
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] t,
                        input logic z, input logic lt, input logic ltu, input logic p,
                        input logic [31:0] tgt);
      bus.ex_valid      = v;
      bus.ex_pc         = pc;
      bus.ex_br_type    = t;
      bus.ex_zero       = z;
      bus.ex_lt         = lt;
      bus.ex_ltu        = ltu;
      bus.ex_pred_taken = p;
      bus.ex_target     = tgt;
      bus.ex_pc_plus4   = pc + 32'd4;
   endtask

   // One live resolve; a redirect is followed by an idle drain cycle.
   task automatic resolve(input logic [31:0] pc, input logic [2:0] t, input logic z,
                          input logic lt, input logic ltu, input logic p,
                          input logic [31:0] tgt, input logic exp_rv,
                          input logic [31:0] exp_rpc, input string tag);
      drive(1'b1, pc, t, z, lt, ltu, p, tgt);
      @(posedge clk);
      #1;
      bus.ex_valid = 1'b0;
      exp_br++;
      if (exp_rv) begin
         exp_mp++;
         held_rpc = exp_rpc;
      end
      chk({tag, ".rv"}, {31'd0, bus.redirect_valid}, {31'd0, exp_rv});
      chk({tag, ".rpc"}, bus.redirect_pc, held_rpc);
      if (exp_rv) begin
         @(posedge clk);
         #1;
         chk({tag, ".rv_drop"}, {31'd0, bus.redirect_valid}, 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.if_pc = 32'd0;
      drive(1'b0, 32'd0, BR_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Reset state
      #12;
      chk("rst.rv", {31'd0, bus.redirect_valid}, 32'd0);
      chk("rst.rpc", bus.redirect_pc, 32'd0);
      stats("rst");
      pred(32'h40, 1'b0, "rst.pred40");
      pred(32'h7C, 1'b0, "rst.pred7c");
      rst_n = 1'b1;

      // Taken BEQ predicted not-taken -> redirect to target, entry 0 -> 10
      resolve(32'h40, BR_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100, "beq");
      pred(32'h40, 1'b1, "beq.pred40");
      pred(32'h80, 1'b1, "beq.alias80");
      pred(32'h48, 1'b0, "beq.pred48");
      stats("beq");

      // BNE saturation at entry 1
      resolve(32'h44, BR_BNE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, "bne1");
      resolve(32'h44, BR_BNE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, "bne2");
      resolve(32'h44, BR_BNE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, "bne3");
      pred(32'h44, 1'b1, "bne3.pred");
      resolve(32'h44, BR_BNE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, "bne4");
      pred(32'h44, 1'b1, "bne4.pred");
      resolve(32'h44, BR_BNE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 32'h0, "bne_nt1");
      pred(32'h44, 1'b1, "bne_nt1.pred");
      resolve(32'h44, BR_BNE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 32'h0, "bne_nt2");
      pred(32'h44, 1'b0, "bne_nt2.pred");

      // Mispredict, then a wrong-path BLT in the redirect cycle is squashed
      drive(1'b1, 32'h48, BR_BLT, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300);
      @(posedge clk);
      #1;
      exp_br++;
      exp_mp++;
      held_rpc = 32'h300;
      chk("blt.rv", {31'd0, bus.redirect_valid}, 32'd1);
      chk("blt.rpc", bus.redirect_pc, 32'h300);
      drive(1'b1, 32'h48, BR_BLT, 1'b0, 1'b1, 1'b0, 1'b0, 32'h340);
      @(posedge clk);
      #1;
      bus.ex_valid = 1'b0;
      chk("squash.rv", {31'd0, bus.redirect_valid}, 32'd0);
      chk("squash.rpc", bus.redirect_pc, 32'h300);
      pred(32'h48, 1'b1, "squash.pred");
      resolve(32'h48, BR_BLT, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 1'b0, 32'h0, "blt_nt");
      pred(32'h48, 1'b0, "blt_nt.pred");

      // BLTU not taken predicted taken -> fall-through; counter floor at 0
      resolve(32'h4C, BR_BLTU, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'h50, "bltu");
      resolve(32'h4C, BR_BGEU, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 1'b0, 32'h0, "bgeu_nt");
      resolve(32'h4C, BR_BGEU, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, "bgeu_t1");
      resolve(32'h4C, BR_BGEU, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, "bgeu_t2");
      pred(32'h4C, 1'b1, "bgeu.pred");

      // JUMP never writes the table
      resolve(32'h40, BR_JUMP, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, "jump_p1");
      resolve(32'h40, BR_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 1'b0, 32'h0, "beq_nt");
      pred(32'h40, 1'b0, "jump.nowrite");
      resolve(32'h54, BR_JUMP, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 1'b1, 32'h600, "jump_p0");
      resolve(32'h50, BR_BGE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h700, 1'b1, 32'h700, "bge");
      pred(32'h50, 1'b1, "bge.pred");

      // NONE is never a resolve
      drive(1'b1, 32'h58, BR_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h800);
      @(posedge clk);
      #1;
      bus.ex_valid = 1'b0;
      chk("none.rv", {31'd0, bus.redirect_valid}, 32'd0);
      chk("none.rpc", bus.redirect_pc, 32'h700);
      stats("mid");

      // Reset during a mispredicting resolve
      drive(1'b1, 32'h44, BR_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 32'h900);
      #1;
      rst_n = 1'b0;
      #1;
      exp_br = 0;
      exp_mp = 0;
      held_rpc = 32'd0;
      chk("arst.rpc", bus.redirect_pc, 32'd0);
      stats("arst");
      @(posedge clk);
      #1;
      bus.ex_valid = 1'b0;
      chk("arst.rv", {31'd0, bus.redirect_valid}, 32'd0);
      pred(32'h40, 1'b0, "arst.pred40");
      pred(32'h48, 1'b0, "arst.pred48");
      pred(32'h4C, 1'b0, "arst.pred4c");
      pred(32'h50, 1'b0, "arst.pred50");
      rst_n = 1'b1;
      resolve(32'h50, BR_BGE, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA00, 1'b0, 32'h0, "post_rst");
      pred(32'h50, 1'b1, "post_rst.pred");
      stats("end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
